// File: rtl/code_slew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : code_slew_ctrl
// Purpose  : Code-phase slew and frequency-word control for a code NCO.
//            A CPU slew request is armed, started on the next code epoch
//            (dump_enable), and then suppresses exactly slew_amount
//            half-chip enables before the gate reopens. The frequency
//            control word is registered on its way to the NCO.
//
// Ports    : clk            - system clock, rising edge
//            rstn           - synchronous active-low reset
//            tic_enable     - one-cycle measurement TIC strobe
//            dump_enable    - one-cycle code-epoch (1 ms) strobe
//            hc_enable_in   - raw half-chip enable from the code NCO
//            f_control_wr   - CPU write strobe for the frequency word
//            f_control_in   - frequency word (FC_W bits)
//            slew_wr        - CPU slew request strobe
//            slew_amount    - half-chips to suppress (SLEW_W bits)
//            f_control_out  - registered frequency word to the NCO
//            hc_enable_out  - gated half-chip enable to the code generator
//            slew_busy      - high while a slew is armed or running
//            slew_done      - one-cycle pulse when a slew completes
//            slew_rejected  - one-cycle pulse when a slew_wr is ignored
//            slew_remaining - half-chips still to be suppressed
//
// Options  : CODE_FCTRL_TIC_SYNC_EN - when defined, frequency-word writes are
//            held pending and applied on the next tic_enable edge. When
//            undefined, a write reaches f_control_out one cycle later.
//
// Revision : 1.0 - initial release
// ============================================================================
module code_slew_ctrl #(
    parameter int FC_W   = 28,
    parameter int SLEW_W = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tic_enable,
    input  logic              dump_enable,
    input  logic              hc_enable_in,
    input  logic              f_control_wr,
    input  logic [FC_W-1:0]   f_control_in,
    input  logic              slew_wr,
    input  logic [SLEW_W-1:0] slew_amount,
    output logic [FC_W-1:0]   f_control_out,
    output logic              hc_enable_out,
    output logic              slew_busy,
    output logic              slew_done,
    output logic              slew_rejected,
    output logic [SLEW_W-1:0] slew_remaining
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_SLEW  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [SLEW_W-1:0] r_remaining;
    logic              r_rejected;
    logic [FC_W-1:0]   r_f_control;
    logic              w_accept;

    // A request is only taken from IDLE with a nonzero amount; every other
    // slew_wr is reported as rejected on the following cycle.
    assign w_accept = slew_wr && (r_state == c_IDLE) && (slew_amount != '0);

    // ------------------------------------------------------------------
    // Slew state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_remaining <= '0;
            r_rejected  <= 1'b0;
        end else begin
            r_rejected <= slew_wr && !w_accept;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_remaining <= slew_amount;
                        r_state     <= c_ARMED;
                    end
                end
                c_ARMED: begin
                    // A dump coincident with the accepting write was seen in
                    // IDLE, so only a later epoch starts the slew.
                    if (dump_enable) begin
                        r_state <= c_SLEW;
                    end
                end
                c_SLEW: begin
                    if (hc_enable_in) begin
                        r_remaining <= r_remaining - SLEW_W'(1);
                        if (r_remaining == SLEW_W'(1)) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                default: begin
                    r_remaining <= '0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    // The gate also opens while rstn is low so the code generator keeps
    // running during reset even before the state register clears.
    assign hc_enable_out  = hc_enable_in && !((r_state == c_SLEW) && rstn);
    assign slew_busy      = (r_state == c_ARMED) || (r_state == c_SLEW);
    assign slew_done      = (r_state == c_DONE);
    assign slew_rejected  = r_rejected;
    assign slew_remaining = r_remaining;

    // ------------------------------------------------------------------
    // Frequency control word
    // ------------------------------------------------------------------
`ifdef CODE_FCTRL_TIC_SYNC_EN
    logic [FC_W-1:0] r_pend_word;
    logic            r_pend;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_f_control <= '0;
            r_pend_word <= '0;
            r_pend      <= 1'b0;
        end else begin
            if (tic_enable && f_control_wr) begin
                // Same-cycle write bypasses the pending register.
                r_f_control <= f_control_in;
                r_pend_word <= f_control_in;
                r_pend      <= 1'b0;
            end else if (f_control_wr) begin
                r_pend_word <= f_control_in;
                r_pend      <= 1'b1;
            end else if (tic_enable && r_pend) begin
                r_f_control <= r_pend_word;
                r_pend      <= 1'b0;
            end
        end
    end
`else
    logic w_unused_tic;
    assign w_unused_tic = tic_enable;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_f_control <= '0;
        end else if (f_control_wr) begin
            r_f_control <= f_control_in;
        end
    end
`endif

    assign f_control_out = r_f_control;

endmodule
`default_nettype wire

// File: tb/tb_code_slew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_slew_ctrl
// Purpose  : Directed self-checking bench for code_slew_ctrl. Inputs change
//            1 time unit after the rising edge; outputs are sampled there.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_code_slew_ctrl;

    localparam int FC_W   = 28;
    localparam int SLEW_W = 11;

    logic              clk;
    logic              rstn;
    logic              tic_enable;
    logic              dump_enable;
    logic              hc_enable_in;
    logic              f_control_wr;
    logic [FC_W-1:0]   f_control_in;
    logic              slew_wr;
    logic [SLEW_W-1:0] slew_amount;
    logic [FC_W-1:0]   f_control_out;
    logic              hc_enable_out;
    logic              slew_busy;
    logic              slew_done;
    logic              slew_rejected;
    logic [SLEW_W-1:0] slew_remaining;

    int r_checks = 0;
    int r_passed = 0;
    int r_done_cnt;
    int r_blocked;

    code_slew_ctrl #(.FC_W(FC_W), .SLEW_W(SLEW_W)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .tic_enable     (tic_enable),
        .dump_enable    (dump_enable),
        .hc_enable_in   (hc_enable_in),
        .f_control_wr   (f_control_wr),
        .f_control_in   (f_control_in),
        .slew_wr        (slew_wr),
        .slew_amount    (slew_amount),
        .f_control_out  (f_control_out),
        .hc_enable_out  (hc_enable_out),
        .slew_busy      (slew_busy),
        .slew_done      (slew_done),
        .slew_rejected  (slew_rejected),
        .slew_remaining (slew_remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got === exp) r_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One hc pulse followed by one idle cycle; tallies blocked pulses and
    // slew_done cycles seen.
    task automatic hc_pulse(output logic passed);
        hc_enable_in = 1'b1;
        #1;
        passed = hc_enable_out;
        if (!hc_enable_out) r_blocked++;
        step();
        hc_enable_in = 1'b0;
        if (slew_done) r_done_cnt++;
        step();
        if (slew_done) r_done_cnt++;
    endtask

    logic pass_bit;

    initial begin
        rstn = 1'b0; tic_enable = 1'b0; dump_enable = 1'b0; hc_enable_in = 1'b0;
        f_control_wr = 1'b0; f_control_in = '0; slew_wr = 1'b0; slew_amount = '0;
        step(); step();
        rstn = 1'b1;
        step();

        // Reset state and transparent gating
        check("rst_fout", 32'(f_control_out), 32'h0);
        check("rst_busy", 32'(slew_busy), 32'h0);
        check("rst_rem", 32'(slew_remaining), 32'h0);
        check("rst_done", 32'(slew_done), 32'h0);
        check("rst_rej", 32'(slew_rejected), 32'h0);
        hc_enable_in = 1'b1; #1;
        check("idle_hc_hi", 32'(hc_enable_out), 32'h1);
        hc_enable_in = 1'b0; #1;
        check("idle_hc_lo", 32'(hc_enable_out), 32'h0);
        step();

        // Slew of 5, dump 10 cycles later, 8 pulses
        slew_wr = 1'b1; slew_amount = 11'd5;
        step();
        slew_wr = 1'b0;
        check("s5_busy", 32'(slew_busy), 32'h1);
        check("s5_rem", 32'(slew_remaining), 32'd5);
        repeat (9) step();
        dump_enable = 1'b1;
        step();
        dump_enable = 1'b0;
        check("s5_rem_start", 32'(slew_remaining), 32'd5);
        r_done_cnt = 0; r_blocked = 0;
        for (int i = 1; i <= 8; i++) begin
            hc_pulse(pass_bit);
            check($sformatf("s5_pulse%0d", i), 32'(pass_bit), (i > 5) ? 32'h1 : 32'h0);
            check($sformatf("s5_rem%0d", i), 32'(slew_remaining), (i >= 5) ? 32'd0 : 32'(5 - i));
        end
        check("s5_done_cnt", 32'(r_done_cnt), 32'd1);
        check("s5_busy_end", 32'(slew_busy), 32'h0);

        // Slew of 3 with coincident dump, then a rejected second request
        slew_wr = 1'b1; slew_amount = 11'd3; dump_enable = 1'b1;
        step();
        slew_wr = 1'b0; dump_enable = 1'b0;
        check("s3_busy", 32'(slew_busy), 32'h1);
        check("s3_rej0", 32'(slew_rejected), 32'h0);
        slew_wr = 1'b1; slew_amount = 11'd7;
        step();
        slew_wr = 1'b0;
        check("s3_rej1", 32'(slew_rejected), 32'h1);
        check("s3_rem_kept", 32'(slew_remaining), 32'd3);
        r_done_cnt = 0; r_blocked = 0;
        hc_pulse(pass_bit);
        check("s3_armed_pass", 32'(pass_bit), 32'h1);
        check("s3_rej_pulse", 32'(slew_rejected), 32'h0);
        dump_enable = 1'b1;
        step();
        dump_enable = 1'b0;
        r_blocked = 0;
        for (int i = 1; i <= 5; i++) hc_pulse(pass_bit);
        check("s3_blocked", 32'(r_blocked), 32'd3);
        check("s3_done_cnt", 32'(r_done_cnt), 32'd1);

        // Reset after 2 of 4 pulses suppressed
        slew_wr = 1'b1; slew_amount = 11'd4;
        step();
        slew_wr = 1'b0; dump_enable = 1'b1;
        step();
        dump_enable = 1'b0;
        r_done_cnt = 0; r_blocked = 0;
        hc_pulse(pass_bit);
        hc_pulse(pass_bit);
        check("rs_blocked2", 32'(r_blocked), 32'd2);
        check("rs_rem2", 32'(slew_remaining), 32'd2);
        rstn = 1'b0;
        hc_enable_in = 1'b1; #1;
        check("rs_hc_in_rst", 32'(hc_enable_out), 32'h1);
        hc_enable_in = 1'b0;
        step();
        rstn = 1'b1;
        check("rs_busy", 32'(slew_busy), 32'h0);
        check("rs_rem", 32'(slew_remaining), 32'd0);
        hc_pulse(pass_bit);
        check("rs_third_pass", 32'(pass_bit), 32'h1);
        step();
        check("rs_no_done", 32'(r_done_cnt), 32'd0);

        // Zero-amount request
        slew_wr = 1'b1; slew_amount = 11'd0;
        step();
        slew_wr = 1'b0;
        check("z_rej", 32'(slew_rejected), 32'h1);
        check("z_busy", 32'(slew_busy), 32'h0);
        dump_enable = 1'b1;
        step();
        dump_enable = 1'b0;
        hc_pulse(pass_bit);
        check("z_pass", 32'(pass_bit), 32'h1);

        // Frequency word path
        f_control_wr = 1'b1; f_control_in = 28'h4000000;
        step();
        f_control_in = 28'h4000100;
`ifdef CODE_FCTRL_TIC_SYNC_EN
        check("fc_hold1", 32'(f_control_out), 32'h0);
        step();
        f_control_wr = 1'b0;
        check("fc_hold2", 32'(f_control_out), 32'h0);
        step();
        check("fc_hold3", 32'(f_control_out), 32'h0);
        tic_enable = 1'b1;
        step();
        tic_enable = 1'b0;
        check("fc_tic", 32'(f_control_out), 32'h4000100);
        f_control_wr = 1'b1; f_control_in = 28'h0000123; tic_enable = 1'b1;
        step();
        f_control_wr = 1'b0; tic_enable = 1'b0;
        check("fc_same", 32'(f_control_out), 32'h0000123);
`else
        check("fc_first", 32'(f_control_out), 32'h4000000);
        step();
        f_control_wr = 1'b0;
        check("fc_second", 32'(f_control_out), 32'h4000100);
        tic_enable = 1'b1;
        step();
        tic_enable = 1'b0;
        check("fc_tic_none", 32'(f_control_out), 32'h4000100);
`endif

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
